// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state encoding, default widths and the HLT match fields.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int DEF_AW = 12;
    localparam int DEF_IW = 16;

    localparam logic [1:0] HLT_OP = 2'b11;
    localparam logic [3:0] HLT_FN = 4'b1111;

endpackage

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches one instruction at a time,
// hands it to decode, squashes wrong-path fetches on jumps and stops on HLT.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int IW = DEF_IW
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [IW-1:0] imem_rdata,
    input  logic          ex_valid,
    input  logic          jflag,
    input  logic [AW-1:0] jdest,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc,
    output logic          halted
);

    state_t        state_reg, state_next;
    logic [AW-1:0] pc_reg, pc_next;
    logic          drop_reg, drop_next;
    logic [IW-1:0] id_instr_reg, id_instr_next;
    logic [AW-1:0] id_pc_reg, id_pc_next;
    logic          redirect;
    logic          is_hlt;

    assign redirect = ex_valid & jflag & (state_reg != HALT);
    assign is_hlt   = (id_instr_reg[15:14] == HLT_OP) && (id_instr_reg[7:4] == HLT_FN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            pc_reg       <= '0;
            drop_reg     <= 1'b0;
            id_instr_reg <= '0;
            id_pc_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            drop_reg     <= drop_next;
            id_instr_reg <= id_instr_next;
            id_pc_reg    <= id_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        drop_next     = drop_reg;
        id_instr_next = id_instr_reg;
        id_pc_next    = id_pc_reg;
        unique case (state_reg)
            IDLE: begin
                state_next = WAIT;
                // The request leaving this cycle carries the stale pc.
                if (redirect) begin
                    pc_next   = jdest;
                    drop_next = 1'b1;
                end
            end
            WAIT: begin
                if (!imem_valid) begin
                    if (redirect) begin
                        pc_next   = jdest;
                        drop_next = 1'b1;
                    end
                end else if (drop_reg || redirect) begin
                    drop_next  = 1'b0;
                    state_next = IDLE;
                    if (redirect) begin
                        pc_next = jdest;
                    end
                end else begin
                    id_instr_next = imem_rdata;
                    id_pc_next    = pc_reg;
                    pc_next       = pc_reg + AW'(1);
                    state_next    = HOLD;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = jdest;
                    state_next = IDLE;
                end else if (id_ready) begin
                    state_next = is_hlt ? HALT : IDLE;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_req  = rst_n && (state_reg == IDLE);
    assign imem_addr = pc_reg;
    assign id_valid  = (state_reg == HOLD) && !redirect;
    assign id_instr  = id_instr_reg;
    assign id_pc     = id_pc_reg;
    assign halted    = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: hand-driven memory responses, jumps and HLT,
// with expected values written out per step.
module tb_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        ex_valid;
    logic        jflag;
    logic [11:0] jdest;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [11:0] id_pc;
    logic        halted;

    int vectors = 0;
    int fails   = 0;

    fetch_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .ex_valid   (ex_valid),
        .jflag      (jflag),
        .jdest      (jdest),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_jump(input logic [11:0] dest);
        ex_valid = 1'b1;
        jflag    = 1'b1;
        jdest    = dest;
    endtask

    task automatic clr_jump();
        ex_valid = 1'b0;
        jflag    = 1'b0;
        jdest    = 12'h000;
    endtask

    // Normal fetch with 1-cycle memory and immediate acceptance; starts in IDLE.
    task automatic normal_fetch(input logic [11:0] a, input logic [15:0] d);
        chk("req_idle", imem_req, 1);
        chk("addr", imem_addr, a);
        tick();
        chk("req_wait", imem_req, 0);
        imem_valid = 1'b1;
        imem_rdata = d;
        tick();
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        chk("id_valid", id_valid, 1);
        chk("id_instr", id_instr, d);
        chk("id_pc", id_pc, a);
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        $display("fetch addr=%03h data=%04h", a, d);
    endtask

    initial begin
        rst_n = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        id_ready = 1'b0;
        clr_jump();
        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_halted", halted, 0);
        chk("rst_id_valid", id_valid, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_instr", id_instr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Straight-line fetch, one instruction per 3 cycles.
        normal_fetch(12'h000, 16'h0001);
        normal_fetch(12'h001, 16'h0002);
        normal_fetch(12'h002, 16'h0003);

        // Decode stall for 4 cycles in HOLD.
        chk("stall_addr", imem_addr, 12'h003);
        tick();
        imem_valid = 1'b1;
        imem_rdata = 16'h1234;
        tick();
        imem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stall_valid", id_valid, 1);
            chk("stall_instr", id_instr, 16'h1234);
            chk("stall_pc", id_pc, 12'h003);
            chk("stall_req", imem_req, 0);
            tick();
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        chk("after_stall_req", imem_req, 1);
        chk("after_stall_addr", imem_addr, 12'h004);
        $display("stall done");

        // Jump while WAITing; stale response arrives 2 cycles later.
        tick();
        set_jump(12'h040);
        tick();
        clr_jump();
        chk("wj_valid0", id_valid, 0);
        chk("wj_req0", imem_req, 0);
        tick();
        imem_valid = 1'b1;
        imem_rdata = 16'h5555;
        tick();
        imem_valid = 1'b0;
        chk("wj_valid1", id_valid, 0);
        chk("wj_req", imem_req, 1);
        chk("wj_addr", imem_addr, 12'h040);
        $display("wait-jump addr=%03h", imem_addr);

        // Jump in HOLD with id_ready=1: squashed, pc+1 never fetched.
        tick();
        imem_valid = 1'b1;
        imem_rdata = 16'h7777;
        tick();
        imem_valid = 1'b0;
        chk("hj_valid_pre", id_valid, 1);
        id_ready = 1'b1;
        set_jump(12'h040);
        #1;
        chk("hj_valid", id_valid, 0);
        tick();
        id_ready = 1'b0;
        clr_jump();
        chk("hj_addr", imem_addr, 12'h040);
        $display("hold-jump addr=%03h", imem_addr);

        // Jump to 0xFFF, then wrap.
        tick();
        imem_valid = 1'b1;
        imem_rdata = 16'h7778;
        tick();
        imem_valid = 1'b0;
        set_jump(12'hFFF);
        tick();
        clr_jump();
        normal_fetch(12'hFFF, 16'h0001);
        normal_fetch(12'h000, 16'h80F0);
        chk("near_hlt_halted", halted, 0);

        // Jump while IDLE: stale request completes, then new one goes out.
        chk("ij_addr_pre", imem_addr, 12'h001);
        set_jump(12'h100);
        tick();
        clr_jump();
        chk("ij_req_wait", imem_req, 0);
        tick();
        imem_valid = 1'b1;
        imem_rdata = 16'h2222;
        tick();
        imem_valid = 1'b0;
        chk("ij_valid", id_valid, 0);
        chk("ij_addr", imem_addr, 12'h100);
        $display("idle-jump addr=%03h", imem_addr);

        // Squashed HLT must not halt.
        tick();
        imem_valid = 1'b1;
        imem_rdata = 16'hC0F0;
        tick();
        imem_valid = 1'b0;
        chk("sq_hlt_valid", id_valid, 1);
        id_ready = 1'b1;
        set_jump(12'h200);
        tick();
        id_ready = 1'b0;
        clr_jump();
        chk("sq_hlt_halted", halted, 0);
        chk("sq_hlt_addr", imem_addr, 12'h200);

        // Accepted HLT.
        normal_fetch(12'h200, 16'hC0F0);
        chk("hlt_halted", halted, 1);
        chk("hlt_req", imem_req, 0);
        chk("hlt_valid", id_valid, 0);
        for (int i = 0; i < 3; i++) begin
            set_jump(12'h300);
            #1;
            chk("hlt_jump_req", imem_req, 0);
            chk("hlt_jump_valid", id_valid, 0);
            tick();
        end
        clr_jump();
        chk("hlt_still", halted, 1);
        $display("halted=%0d", halted);

        // Asynchronous reset from HALT, then fetch restarts at 0.
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_halted", halted, 0);
        chk("rst2_req", imem_req, 0);
        chk("rst2_id_pc", id_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst2_req_on", imem_req, 1);
        chk("rst2_addr", imem_addr, 12'h000);
        $display("restart addr=%03h", imem_addr);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that owns the 12-bit program counter, fetches one instruction at a time from instruction memory and presents it with its address to the decode stage. It is the consumer of the jump decision `jdest`/`jflag` produced in execute: on a taken jump it redirects the PC and squashes the wrong-path fetch. It also detects HLT and stops fetching.

## Interface
Parameters:
- `AW`, 12: PC / instruction address width
- `IW`, 16: instruction width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  fetch request; one outstanding at most
- `imem_addr`  out  AW  fetch address, valid while `imem_req`=1
- `imem_valid`  in  1  response strobe, 1 cycle, ≥1 cycle after `imem_req`
- `imem_rdata`  in  IW  instruction, valid with `imem_valid`
- `ex_valid`  in  1  execute stage holds a resolved instruction
- `jflag`  in  1  jump taken; meaningful only with `ex_valid`
- `jdest`  in  AW  jump target, already wrapped modulo 2^AW
- `id_valid`  out  1  instruction available to decode
- `id_ready`  in  1  decode accepts
- `id_instr`  out  IW  held instruction
- `id_pc`  out  AW  address of `id_instr`
- `halted`  out  1  HLT accepted; sticky until reset

## Operation
- `redirect` = `ex_valid & jflag`; ignored in HALT.
- Reset values: state IDLE, pc=0, drop=0, `id_valid`=0, `id_instr`=0, `id_pc`=0, `halted`=0, `imem_req`=0 while `rst_n`=0.
- `imem_req` = (state==IDLE); `imem_addr` = pc.
- States:
  - IDLE: request goes out this cycle → WAIT. If `redirect`, then pc←`jdest` and drop←1, because the request already issued used the stale pc.
  - WAIT, `imem_valid`=0: if `redirect`, then pc←`jdest` and drop←1. Stay in WAIT.
  - WAIT, `imem_valid`=1:
    - If drop=1 or `redirect`: discard `imem_rdata`, drop←0, → IDLE. If `redirect`, pc←`jdest`.
    - Otherwise: `id_instr`←`imem_rdata`, `id_pc`←pc, pc←pc+1 (wraps 0xFFF→0x000), → HOLD.
  - HOLD:
    - `id_valid`=1 and outputs held stable.
    - If `redirect`: pc←`jdest`, → IDLE, no handshake counted.
    - Otherwise, on `id_ready`: → IDLE, or → HALT if `id_instr` is HLT.
  - HALT: `imem_req`=0, `id_valid`=0, `halted`=1. Only reset exits.
- `id_valid` = (state==HOLD) & ~`redirect`. This is the only combinational input→output path. A handshake in a redirect cycle never occurs.
- HLT is decoded as `id_instr[15:14]`==2'b11 and `id_instr[7:4]`==4'b1111 (0xC0F0 class).
- HLT is acted on only when accepted, never when squashed.
- A jump's `jdest` is computed from the jump's own pc. `fetch_seq` never adds to `jdest`.

## Timing
- Best-case throughput: one instruction per 3 cycles with 1-cycle memory latency (IDLE, WAIT, HOLD with `id_ready`=1).
- Redirect to new request:
  - From HOLD, or WAIT with a same-cycle response: next cycle IDLE issues `jdest`.
  - From IDLE, or WAIT without a response: the request waits until the stale response arrives, then goes out one cycle later.
- Back-to-back redirects: the last one wins. pc takes the most recent `jdest`, and drop stays 1 until one response is consumed.
- Reset mid-operation clears everything asynchronously. The memory side is reset by the same `rst_n`, so no stale response follows reset.

## Structure
- Shared package `fetch_pkg`:
  - state enum {IDLE, WAIT, HOLD, HALT}
  - `AW`/`IW` defaults
  - HLT match constants (opcode 2'b11, function 4'b1111)
- Single module, no sub-module: a state register, pc register, drop flag and the `id_*` holding registers.

## Test plan
- Reset, 1-cycle memory returning 0x0001/0x0002/0x0003, `id_ready`=1 → requests at 0x000, 0x001, 0x002 every 3 cycles; `id_pc`=0,1,2 paired with the matching `id_instr`.
- `id_ready`=0 for 4 cycles in HOLD → `id_instr`/`id_pc` stable, no `imem_req`; the next request goes out one cycle after acceptance.
- `redirect` with `jdest`=0x040 while in WAIT, response arriving 2 cycles later → data dropped, `id_valid` stays 0, next `imem_addr`=0x040.
- `redirect` with `jdest`=0x040 in HOLD with `id_ready`=1 in the same cycle → `id_valid`=0 that cycle, next request at 0x040; the previous pc+1 is never fetched.
- pc=0xFFF fetched and accepted → next `imem_addr`=0x000.
- HLT 0xC0F0 accepted → `halted`=1 the next cycle, no further `imem_req` even with `redirect` pulses; `rst_n` low then high → `halted`=0, fetch resumes at 0x000.
